mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with the HI/LO register pair for the MIPS datapath. It sits in the EX stage beside the ALU and takes operand A from the register file and operand B from the ALU B-operand select output. A two-state sequencer models the MULT/MULTU/DIV/DIVU latency and raises `busy` so the hazard unit can stall. MTHI/MTLO write the registers directly; MFHI/MFLO read them combinationally.

---
 rtl/mult_div_unit.sv | 130 +++++++++++++
 tb/tb_mult_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the MIPS HI/LO register pair.
// A fixed-latency IDLE/RUN sequencer raises busy; the result is a single combinational operator committed on the last RUN edge.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        readHi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdData
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, q_s, r_s;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_mag  = (op_q == OP_DIV && a_q[31]) ? (32'd0 - a_q) : a_q;
    b_mag  = (op_q == OP_DIV && b_q[31]) ? (32'd0 - b_q) : b_q;
    div_b  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / div_b;
    r_mag  = a_mag % div_b;
    q_s    = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    r_s    = a_q[31] ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_d     = srcA;
              b_d     = srcB;
              op_d    = op;
              cnt_d   = (op == OP_MULT || op == OP_MULTU) ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = srcA;
            OP_MTLO: lo_d = srcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: if (b_q != 32'd0) begin
              hi_d = r_s;
              lo_d = q_s;
            end
            OP_DIVU: if (b_q != 32'd0) begin
              hi_d = r_mag;
              lo_d = q_mag;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign rdData = readHi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, readHi;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hi, lo, rdData;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .readHi(readHi), .busy(busy), .hi(hi), .lo(lo), .rdData(rdData)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: HI/LO after an op, computed with 64-bit integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
      3'd4: if (b != 0) begin qu = ua / ub; ru = ua % ub; m_hi = ru[31:0]; m_lo = qu[31:0]; end
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
    readHi = 1'b1; #1;
    check({tag, "_rd_hi"}, rdData, m_hi);
    readHi = 1'b0; #1;
    check({tag, "_rd_lo"}, rdData, m_lo);
  endtask

  // Issue a multi-cycle op; operands are scrambled after the start edge.
  // inject=1 pulses MTHI/MTLO starts while busy (including the final RUN edge) that must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int n;
    n = (o <= 3'd2) ? MC : DC;
    start = 1'b1; op = o; srcA = a; srcB = b;
    tick();
    start = 1'b0; op = 3'd0; srcA = $urandom; srcB = $urandom;
    model(o, a, b);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      if (inject && (i == 1 || i == n - 1)) begin
        start = 1'b1; op = (i == 1) ? 3'd5 : 3'd6; srcA = 32'h0000DEAD;
      end else begin
        start = 1'b0; op = 3'd0;
      end
      tick();
    end
    start = 1'b0; op = 3'd0;
    check_regs(tag);
  endtask

  task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; srcA = v;
    readHi = (o == 3'd5); #1;
    check({tag, "_nobypass"}, rdData, (o == 3'd5) ? m_hi : m_lo);
    tick();
    start = 1'b0; op = 3'd0;
    if (o == 3'd5) m_hi = v; else m_lo = v;
    check_regs(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; srcA = 32'd0; srcB = 32'd0; readHi = 1'b0;
    tick(); tick();
    check_regs("reset");
    reset = 1'b0;

    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_hi_const", hi, 32'hFFFFFFFF);
    check("mult_lo_const", lo, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("multu_hi_const", hi, 32'h00000002);
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_const", lo, 32'hFFFFFFFD);
    check("div_hi_const", hi, 32'hFFFFFFFF);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo_const", lo, 32'h80000000);

    mt("mthi", 3'd5, 32'h00001234);
    mt("mtlo", 3'd6, 32'h00005678);
    run_op("divu_zero", 3'd4, 32'h00000099, 32'd0, 1'b0);
    check("divu_zero_hi_const", hi, 32'h00001234);
    run_op("div_zero", 3'd3, 32'h80000001, 32'd0, 1'b0);

    run_op("mult_inject", 3'd1, 32'h00012345, 32'h00006789, 1'b1);
    run_op("div_inject", 3'd3, 32'h7FFFFFF0, 32'hFFFFFFF3, 1'b1);

    // Back-to-back start on the first idle cycle.
    run_op("b2b", 3'd4, 32'hFFFFFFFF, 32'd7, 1'b0);

    for (int k = 0; k < 12; k++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (k % 3 == 0) rb = rb >> $urandom_range(0, 31);
      run_op("rand", ro, ra, rb, k[0]);
      if (k % 4 == 1) mt("rand_mt", ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd6, $urandom);
    end

    // Abort a DIV with reset in its fourth busy cycle.
    mt("pre_abort", 3'd5, 32'h00001111);
    start = 1'b1; op = 3'd3; srcA = 32'd100; srcB = 32'd7;
    tick();
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check("abort_busy_run", {31'd0, busy}, 32'd1);
      tick();
    end
    reset = 1'b1; start = 1'b1; op = 3'd5; srcA = 32'hCAFE0000;
    tick();
    reset = 1'b0; start = 1'b0; op = 3'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    check_regs("abort");
    repeat (10) tick();
    check_regs("abort_late");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
